// File: rtl/led_shift_pkg.sv
// Shared definitions for the shift-register LED driver: FSM encoding and
// constant functions that derive cycle counts from the clock/rate parameters.
package led_shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  function automatic int unsigned led_time_cyc(input int unsigned sysclk_f,
                                               input int unsigned led_hz);
    return sysclk_f / led_hz;
  endfunction

  function automatic int unsigned shift_time_cyc(input int unsigned sysclk_f,
                                                 input int unsigned shift_hz);
    return sysclk_f / shift_hz;
  endfunction

  function automatic int unsigned pwm_div(input int unsigned sysclk_f,
                                          input int unsigned led_hz,
                                          input int unsigned steps);
    return sysclk_f / (led_hz * steps);
  endfunction

  function automatic int unsigned dim_res(input int unsigned steps);
    return $clog2(steps);
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned ctr_width(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// Free-running PWM dimmer: prescaler advances a wrapping step counter that is
// compared against the active brightness to drive the active-low output enable.
module led_pwm_gen
  import led_shift_pkg::*;
#(
  parameter int unsigned DIMMING_STEPS = 16,
  parameter int unsigned PWM_DIV       = 750
) (
  input  logic                               sys_clk,
  input  logic                               rst,
  input  logic [dim_res(DIMMING_STEPS):0]    bright_act,
  output logic                               led_oe_n
);

  localparam int unsigned DIM_RES = dim_res(DIMMING_STEPS);
  localparam int unsigned PRE_W   = ctr_width(PWM_DIV);

  logic [PRE_W-1:0]   pre_ctr_r;
  logic [DIM_RES-1:0] pwm_ctr_r;
  logic               pwm_step_s;
  logic               on_s;

  assign pwm_step_s = (pre_ctr_r == PRE_W'(PWM_DIV - 32'd1));
  // Zero-extended compare so brightness >= DIMMING_STEPS is always on.
  assign on_s       = ({1'b0, pwm_ctr_r} < bright_act);

  // Prescaler and wrapping PWM step counter.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      pre_ctr_r <= '0;
      pwm_ctr_r <= '0;
    end else if (pwm_step_s) begin
      pre_ctr_r <= '0;
      pwm_ctr_r <= pwm_ctr_r + 1'b1;
    end else begin
      pre_ctr_r <= pre_ctr_r + 1'b1;
    end
  end

  // Registered output enable.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      led_oe_n <= 1'b1;
    end else begin
      led_oe_n <= ~on_s;
    end
  end

endmodule

// File: rtl/led_shift_driver.sv
// Periodic serial driver for a 74HC595-style LED chain: shifts a shadowed
// pattern out every refresh tick, strobes the latch, and PWM-dims the array.
module led_shift_driver
  import led_shift_pkg::*;
#(
  parameter int unsigned SYSCLK_F      = 12000000,
  parameter int unsigned LED_HZ        = 1000,
  parameter int unsigned LED_SHIFT_HZ  = 2000000,
  parameter int unsigned LED_CT        = 16,
  parameter int unsigned DIMMING_STEPS = 16,
  parameter bit          MSB_FIRST     = 1'b0
) (
  input  logic                            sys_clk,
  input  logic                            rst,
  input  logic [LED_CT-1:0]               data,
  input  logic [dim_res(DIMMING_STEPS):0] brightness,
  input  logic                            update,
  output logic                            led_do,
  output logic                            led_clk,
  output logic                            led_latch,
  output logic                            led_oe_n,
  output logic                            busy
);

  localparam int unsigned DIM_RES        = dim_res(DIMMING_STEPS);
  localparam int unsigned LED_TIME_CYC   = led_time_cyc(SYSCLK_F, LED_HZ);
  localparam int unsigned SHIFT_TIME_CYC = shift_time_cyc(SYSCLK_F, LED_SHIFT_HZ);
  localparam int unsigned HALF           = SHIFT_TIME_CYC / 32'd2;
  localparam int unsigned PWM_DIV        = pwm_div(SYSCLK_F, LED_HZ, DIMMING_STEPS);
  localparam int unsigned REF_W          = ctr_width(LED_TIME_CYC);
  localparam int unsigned PH_W           = ctr_width(SHIFT_TIME_CYC);
  localparam int unsigned BIT_W          = ctr_width(LED_CT);

  localparam logic [REF_W-1:0] REF_LAST   = REF_W'(LED_TIME_CYC - 32'd1);
  localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(SHIFT_TIME_CYC - 32'd1);
  localparam logic [PH_W-1:0]  PH_HALF    = PH_W'(HALF);
  localparam logic [PH_W-1:0]  LATCH_LAST = PH_W'(HALF - 32'd1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(LED_CT - 32'd1);

  if (LED_CT < 32'd1) begin : g_bad_led_ct
    $error("led_shift_driver: LED_CT must be at least 1");
  end
  if ((DIMMING_STEPS < 32'd2) || ((DIMMING_STEPS & (DIMMING_STEPS - 32'd1)) != 32'd0)) begin : g_bad_dim
    $error("led_shift_driver: DIMMING_STEPS must be a power of two >= 2");
  end
  if ((SHIFT_TIME_CYC < 32'd2) || ((SHIFT_TIME_CYC % 32'd2) != 32'd0)) begin : g_bad_shift
    $error("led_shift_driver: SHIFT_TIME_CYC must be even and >= 2");
  end
  if (PWM_DIV < 32'd1) begin : g_bad_pwm
    $error("led_shift_driver: PWM_DIV must be >= 1");
  end
  if ((LED_CT * SHIFT_TIME_CYC + HALF) >= LED_TIME_CYC) begin : g_bad_frame
    $error("led_shift_driver: frame does not fit in one refresh period");
  end

  logic [REF_W-1:0]  ref_ctr_r;
  logic              tick_s;
  logic [LED_CT-1:0] data_shadow_r;
  logic [DIM_RES:0]  bright_shadow_r;
  logic [DIM_RES:0]  bright_act_r;
  state_t            state_r;
  state_t            state_s;
  logic [LED_CT-1:0] sreg_r;
  logic [LED_CT-1:0] sreg_s;
  logic [BIT_W-1:0]  bit_ctr_r;
  logic [BIT_W-1:0]  bit_ctr_s;
  logic [PH_W-1:0]   ph_r;
  logic [PH_W-1:0]   ph_s;
  logic              bright_load_s;
  logic              led_do_s;
  logic              led_clk_s;
  logic              led_latch_s;

  assign tick_s = (ref_ctr_r == REF_LAST);

  // Refresh counter, wrapping exactly at LED_TIME_CYC.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      ref_ctr_r <= '0;
    end else if (tick_s) begin
      ref_ctr_r <= '0;
    end else begin
      ref_ctr_r <= ref_ctr_r + 1'b1;
    end
  end

  // Shadow registers for pattern/brightness and the active brightness.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      data_shadow_r   <= '0;
      bright_shadow_r <= '0;
      bright_act_r    <= '0;
    end else begin
      if (update) begin
        data_shadow_r   <= data;
        bright_shadow_r <= brightness;
      end
      if (bright_load_s) begin
        bright_act_r <= bright_shadow_r;
      end
    end
  end

  // FSM next-state, shift register and counter updates.
  always_comb begin
    state_s       = state_r;
    sreg_s        = sreg_r;
    bit_ctr_s     = bit_ctr_r;
    ph_s          = ph_r;
    bright_load_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (tick_s) begin
          state_s   = SHIFT;
          sreg_s    = data_shadow_r;
          bit_ctr_s = '0;
          ph_s      = '0;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (ph_r == PH_LAST) begin
          ph_s = '0;
          if (bit_ctr_r == BIT_LAST) begin
            state_s = LATCH;
          end else begin
            bit_ctr_s = bit_ctr_r + 1'b1;
            sreg_s    = MSB_FIRST ? (sreg_r << 1'b1) : (sreg_r >> 1'b1);
          end
        end else begin
          ph_s = ph_r + 1'b1;
        end
      end
      LATCH: begin
        if (ph_r == LATCH_LAST) begin
          state_s       = IDLE;
          ph_s          = '0;
          bright_load_s = 1'b1;
        end else begin
          ph_s = ph_r + 1'b1;
        end
      end
      default: begin
        state_s   = IDLE;
        ph_s      = '0;
        bit_ctr_s = '0;
      end
    endcase
  end

  // Outputs follow the next state so the first bit appears one cycle after tick.
  always_comb begin
    led_do_s    = 1'b0;
    led_clk_s   = 1'b0;
    led_latch_s = 1'b0;
    case (state_s)
      IDLE: begin
        led_latch_s = 1'b0;
      end
      SHIFT: begin
        led_do_s  = MSB_FIRST ? sreg_s[LED_CT-1] : sreg_s[0];
        led_clk_s = (ph_s >= PH_HALF);
      end
      LATCH: begin
        led_latch_s = 1'b1;
      end
      default: begin
        led_latch_s = 1'b0;
      end
    endcase
  end

  // FSM state, datapath and registered serial outputs.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      sreg_r    <= '0;
      bit_ctr_r <= '0;
      ph_r      <= '0;
      led_do    <= 1'b0;
      led_clk   <= 1'b0;
      led_latch <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_s;
      sreg_r    <= sreg_s;
      bit_ctr_r <= bit_ctr_s;
      ph_r      <= ph_s;
      led_do    <= led_do_s;
      led_clk   <= led_clk_s;
      led_latch <= led_latch_s;
      busy      <= (state_s != IDLE);
    end
  end

  led_pwm_gen #(
    .DIMMING_STEPS (DIMMING_STEPS),
    .PWM_DIV       (PWM_DIV)
  ) u_pwm (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .bright_act (bright_act_r),
    .led_oe_n   (led_oe_n)
  );

endmodule

// File: tb/tb_led_shift_driver.sv
// Directed bench for led_shift_driver: an LSB-first and an MSB-first instance
// share stimulus; frames, latch, busy, dimming, update timing and reset are checked.
module tb_led_shift_driver;

  logic        sys_clk;
  logic        clk_en;
  logic        rst;
  logic [15:0] data;
  logic [4:0]  brightness;
  logic        update;
  logic        do_l, clk_l, latch_l, oe_l, busy_l;
  logic        do_m, clk_m, latch_m, oe_m, busy_m;

  int checks;
  int failures;
  int cyc;

  led_shift_driver #(.MSB_FIRST(1'b0)) u_lsb (
    .sys_clk (sys_clk), .rst (rst), .data (data), .brightness (brightness),
    .update (update), .led_do (do_l), .led_clk (clk_l), .led_latch (latch_l),
    .led_oe_n (oe_l), .busy (busy_l)
  );

  led_shift_driver #(.MSB_FIRST(1'b1)) u_msb (
    .sys_clk (sys_clk), .rst (rst), .data (data), .brightness (brightness),
    .update (update), .led_do (do_m), .led_clk (clk_m), .led_latch (latch_m),
    .led_oe_n (oe_m), .busy (busy_m)
  );

  initial sys_clk = 1'b0;
  always begin
    #5;
    if (clk_en) sys_clk = ~sys_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) @(posedge sys_clk);
    #1;
    cyc += n;
  endtask

  task automatic goto_cyc(input int t);
    if (t > cyc) adv(t - cyc);
  endtask

  // Called in the tick cycle T; observes cycles T+1..T+101.
  task automatic run_frame(input string tag, input logic [15:0] exp_l, input logic [15:0] exp_m,
                           input int upd_off, input logic [15:0] upd_d, input logic [4:0] upd_b,
                           output int oe_low);
    logic [15:0] cap_l, cap_m;
    logic        pclk_l, pclk_m;
    int edges_l, edges_m, bn_l, bn_m, ln_l, ln_m, bad, first_edge, last_edge, first_latch, t0;
    t0 = cyc;
    cap_l = '0; cap_m = '0;
    edges_l = 0; edges_m = 0; bn_l = 0; bn_m = 0; ln_l = 0; ln_m = 0; bad = 0;
    first_edge = -1; last_edge = -1; first_latch = -1; oe_low = 0;
    chk({tag, "_idle_at_tick"}, 32'({busy_m, busy_l}), 32'd0);
    pclk_l = clk_l;
    pclk_m = clk_m;
    for (int k = 0; k <= 100; k++) begin
      if (k == upd_off) begin
        data = upd_d;
        brightness = upd_b;
        update = 1'b1;
      end
      adv(1);
      update = 1'b0;
      if (k == 0) begin
        chk({tag, "_first_bit"}, 32'({do_m, do_l}), 32'({exp_m[0], exp_l[0]}));
        chk({tag, "_busy_start"}, 32'({busy_m, busy_l}), 32'd3);
      end
      if (busy_l) bn_l++;
      if (busy_m) bn_m++;
      if (clk_l && !pclk_l) begin
        if (edges_l < 16) cap_l[edges_l] = do_l;
        if (edges_l == 0) first_edge = cyc - t0;
        last_edge = cyc - t0;
        edges_l++;
      end
      if (clk_m && !pclk_m) begin
        if (edges_m < 16) cap_m[edges_m] = do_m;
        edges_m++;
      end
      if (latch_l) begin
        ln_l++;
        if (first_latch < 0) first_latch = cyc - t0;
        if (do_l || clk_l) bad++;
      end
      if (latch_m) begin
        ln_m++;
        if (do_m || clk_m) bad++;
      end
      if (k < 99 && (!oe_l || !oe_m)) oe_low++;
      pclk_l = clk_l;
      pclk_m = clk_m;
    end
    chk({tag, "_edges_lsb"}, 32'(edges_l), 32'd16);
    chk({tag, "_edges_msb"}, 32'(edges_m), 32'd16);
    chk({tag, "_bits_lsb"}, 32'(cap_l), 32'(exp_l));
    chk({tag, "_bits_msb"}, 32'(cap_m), 32'(exp_m));
    chk({tag, "_first_edge"}, 32'(first_edge), 32'd4);
    chk({tag, "_last_edge"}, 32'(last_edge), 32'd94);
    chk({tag, "_busy_lsb"}, 32'(bn_l), 32'd99);
    chk({tag, "_busy_msb"}, 32'(bn_m), 32'd99);
    chk({tag, "_latch_lsb"}, 32'(ln_l), 32'd3);
    chk({tag, "_latch_msb"}, 32'(ln_m), 32'd3);
    chk({tag, "_latch_start"}, 32'(first_latch), 32'd97);
    chk({tag, "_latch_quiet"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int n_a, n_b, oe_low;
    checks = 0; failures = 0; cyc = 0;
    clk_en = 1'b1;
    rst = 1'b1; data = '0; brightness = '0; update = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset_outputs_lsb", 32'({do_l, clk_l, latch_l, oe_l, busy_l}), 32'h02);
    chk("reset_outputs_msb", 32'({do_m, clk_m, latch_m, oe_m, busy_m}), 32'h02);

    rst = 1'b0;
    cyc = 0;
    data = 16'hA5C3; brightness = 5'd8; update = 1'b1;
    adv(1);
    update = 1'b0;
    n_a = 0; n_b = 0;
    while (cyc < 11999) begin
      if (busy_l || busy_m) n_a++;
      if (!oe_l || !oe_m) n_b++;
      adv(1);
    end
    chk("pre_frame_busy", 32'(n_a), 32'd0);
    chk("pre_latch_oe_off", 32'(n_b), 32'd0);

    run_frame("f1", 16'hA5C3, 16'hC3A5, -1, 16'h0000, 5'd0, oe_low);
    chk("f1_oe_off_until_latch", 32'(oe_low), 32'd0);

    goto_cyc(12199);
    n_a = 0; n_b = 0;
    for (int i = 0; i < 12000; i++) begin
      if (!oe_l) n_a++;
      if (!oe_m) n_b++;
      adv(1);
    end
    chk("dim8_on_lsb", 32'(n_a), 32'd6000);
    chk("dim8_on_msb", 32'(n_b), 32'd6000);

    goto_cyc(35999);
    run_frame("f3_tick_update", 16'hA5C3, 16'hC3A5, 0, 16'h00FF, 5'd8, oe_low);

    goto_cyc(47999);
    run_frame("f4_mid_update", 16'h00FF, 16'hFF00, 33, 16'h1234, 5'd16, oe_low);
    goto_cyc(48199);
    n_a = 0;
    for (int i = 0; i < 2000; i++) begin
      if (oe_l || oe_m) n_a++;
      adv(1);
    end
    chk("dim16_full_on", 32'(n_a), 32'd0);

    goto_cyc(50000);
    brightness = 5'd0; update = 1'b1;
    adv(1);
    update = 1'b0;
    goto_cyc(59999);
    run_frame("f5", 16'h1234, 16'h2C48, -1, 16'h0000, 5'd0, oe_low);
    goto_cyc(60199);
    n_a = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!oe_l || !oe_m) n_a++;
      adv(1);
    end
    chk("dim0_full_off", 32'(n_a), 32'd0);

    goto_cyc(65000);
    data = 16'hFFFF; brightness = 5'd31; update = 1'b1;
    adv(1);
    update = 1'b0;
    goto_cyc(72046);
    chk("bit7_before_reset", 32'({do_m, do_l, clk_m, clk_l, busy_m, busy_l}), 32'h3F);

    clk_en = 1'b0;
    #20;
    rst = 1'b1;
    #1;
    chk("async_reset_lsb", 32'({do_l, clk_l, latch_l, oe_l, busy_l}), 32'h02);
    chk("async_reset_msb", 32'({do_m, clk_m, latch_m, oe_m, busy_m}), 32'h02);
    #20;
    clk_en = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    n_a = 0;
    while (cyc < 11999) begin
      if (latch_l || latch_m || busy_l || busy_m || do_l || do_m) n_a++;
      adv(1);
    end
    chk("post_reset_quiet", 32'(n_a), 32'd0);
    run_frame("f_after_reset", 16'h0000, 16'h0000, -1, 16'h0000, 5'd0, oe_low);
    chk("post_reset_oe_off", 32'(oe_low), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_shift_driver.md
# led_shift_driver

Parametrised serial driver for a chain of shift-register LED drivers (74HC595 class). It periodically shifts an `LED_CT`-bit pattern out on data/clock lines, strobes a latch, and dims the whole array by PWM on an active-low output-enable. It sits between the register/UART-facing logic (which supplies `data`/`brightness` plus an `update` strobe) and the board LED/seven-segment pins. It is the generalised successor to the fixed 8-LED shifter: any chain length, selectable bit order, a latch strobe, and real dimming.

## Interface
- `SYSCLK_F`, 12000000: system clock frequency in Hz.
- `LED_HZ`, 1000: refresh frame rate in Hz.
- `LED_SHIFT_HZ`, 2000000: serial bit rate in Hz.
- `LED_CT`, 16: number of output bits in the chain. Must be ≥ 1.
- `DIMMING_STEPS`, 16: PWM levels per PWM period. Must be a power of two, ≥ 2.
- `MSB_FIRST`, 0: 0 shifts `data[0]` first; 1 shifts `data[LED_CT-1]` first.
- `sys_clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `data` in `LED_CT`: pattern to display.
- `brightness` in `DIM_RES+1`, where `DIM_RES`=clog2(`DIMMING_STEPS`): on-time in PWM steps. Values ≥ `DIMMING_STEPS` mean fully on.
- `update` in 1: when high on a clock edge, `data` and `brightness` are copied into the shadow registers.
- `led_do` out 1: serial data.
- `led_clk` out 1: shift clock. The chain samples on its rising edge.
- `led_latch` out 1: storage-register strobe, active high.
- `led_oe_n` out 1: output enable, active low, PWM-modulated.
- `busy` out 1: high while a frame is shifting or latching.

## Operation
- Derived constants:
  - `LED_TIME_CYC` = `SYSCLK_F`/`LED_HZ`.
  - `SHIFT_TIME_CYC` = `SYSCLK_F`/`LED_SHIFT_HZ`.
  - `HALF` = `SHIFT_TIME_CYC`/2.
  - `PWM_DIV` = `SYSCLK_F`/(`LED_HZ`·`DIMMING_STEPS`).
- Elaboration fails unless all of the following hold:
  - `SHIFT_TIME_CYC` is ≥ 2 and even.
  - `PWM_DIV` ≥ 1.
  - `LED_CT`·`SHIFT_TIME_CYC`+`HALF` < `LED_TIME_CYC`.

  Because of the last check, a frame can never be overrun by the next tick.
- Refresh counter:
  - Counts 0..`LED_TIME_CYC`-1 and wraps exactly; wrap is not power-of-two truncated.
  - `tick` is asserted when the count equals `LED_TIME_CYC`-1.
- FSM states are IDLE, SHIFT, LATCH.
  - **IDLE → SHIFT on `tick`.** The shift register loads `data_shadow` as it stood before this edge, so an `update` in the same cycle affects the next frame. The bit counter and the phase counter clear.
  - **SHIFT:** each bit occupies `SHIFT_TIME_CYC` cycles.
    - `led_do` presents the bit from the first cycle of the bit period.
    - `led_clk` is 0 for the first `HALF` cycles and 1 for the remaining `HALF` cycles.
    - At the end of the bit period, `led_clk` returns to 0 and the next bit is presented on the same edge.
    - After bit `LED_CT`-1 the FSM goes to LATCH.
  - **LATCH:** `led_do`=0, `led_clk`=0, `led_latch`=1 for `HALF` cycles.
    - On exit, `bright_act` ← `bright_shadow`, so the new pattern and new brightness take effect together.
    - The FSM then returns to IDLE.
- `busy` = (state ≠ IDLE).
- PWM:
  - A prescaler of `PWM_DIV` cycles advances a `DIM_RES`-bit counter, which wraps freely.
  - `led_oe_n` = !(`pwm_ctr` < `bright_act`). Comparison is unsigned and `DIM_RES`+1 bits wide.
  - `bright_act`=0 → `led_oe_n` is constantly 1. `bright_act`≥`DIMMING_STEPS` → `led_oe_n` is constantly 0.
  - The PWM counters run independently of the FSM.
- Reset, including mid-frame: asynchronously forces the following.
  - Outputs: `led_do`=0, `led_clk`=0, `led_latch`=0, `led_oe_n`=1, `busy`=0.
  - FSM: IDLE.
  - Counters: all 0.
  - Shadow and active registers: 0.
  - No partial latch pulse is emitted.

## Timing
- Latency from a `tick` edge to the first bit on `led_do`: 1 cycle.
- Frame length: `LED_CT`·`SHIFT_TIME_CYC`+`HALF` cycles of `busy`.
- Setup/hold at the chain: `HALF` cycles each around every rising `led_clk` edge.
- After `rst` deasserts, the first `tick` falls at cycle `LED_TIME_CYC`-1. Ticks then repeat every `LED_TIME_CYC` cycles.
- `update` to visible output: at most one refresh period plus one frame.
- `led_oe_n` is registered. Brightness changes take effect on the cycle after the LATCH exit.

## Structure
- Shared package `led_shift_pkg` holds:
  - the FSM state encoding (IDLE, SHIFT, LATCH);
  - constant functions for the derived cycle counts and `DIM_RES`.
- Sub-module `led_pwm_gen` holds the prescaler, the PWM counter and the compare. Its only inputs are `bright_act` and the reset.
- The top level contains the refresh counter, the shadow registers, the FSM and the shift register.

## Test plan
All scenarios use default parameters: `LED_TIME_CYC`=12000, `SHIFT_TIME_CYC`=6, `HALF`=3, frame = 99 cycles, `PWM_DIV`=750.

- **LSB-first frame.** Reset, then `update` with `data`=16'hA5C3.
  - First bit appears at cycle 12000.
  - `led_do` at each of the 16 `led_clk` rising edges (6 cycles apart) reads 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
  - `led_latch` is high for 3 cycles; `busy` is high for 99 cycles.
- **MSB-first frame.** `MSB_FIRST`=1 with the same data.
  - Edge-sampled sequence is 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1.
- **Dimming.**
  - `brightness`=8: `led_oe_n` is low for 6000 of every 12000 cycles once the latch has completed.
  - `brightness`=0: `led_oe_n` is constantly 1.
  - `brightness`=16 or 31: `led_oe_n` is constantly 0.
  - Before the first latch, `led_oe_n` stays 1.
- **Update timing.**
  - `update` with 16'h00FF on the same cycle as `tick`: the current frame shifts the old shadow value; 16'h00FF appears in the next frame.
  - `update` mid-frame: the in-flight bits are unchanged.
- **Reset mid-frame.** Assert `rst` during bit 7 with `sys_clk` stopped.
  - All outputs take their reset values immediately.
  - After release, the next frame starts at cycle 12000 and shifts all zeros.
  - No `led_latch` pulse occurs in between.
